bht_port_scheduler: RTL and testbench

Sequences the single-ported 2-bit-counter branch history table between two requesters:
- fetch-stage prediction lookups;
- execute-stage resolution updates, which need a read-modify-write of the counter.

The block also clears the table after reset and buffers resolved updates in a small queue. It sits between the fetch/execute pipeline stages and the BHT storage.

---
 rtl/bht_sched_pkg.sv | 26 ++
 rtl/bht_port_scheduler_if.sv | 33 +++
 rtl/bht_update_fifo.sv | 63 ++++++
 rtl/bht_port_scheduler.sv | 132 +++++++++++++
 tb/tb_bht_port_scheduler.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bht_sched_pkg.sv
// Shared types for the BHT port scheduler: FSM states, 2-bit counter
// encodings and the saturating counter update.
package bht_sched_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    UPD_WR = 2'd2
  } sched_state_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    if (taken) begin
      r = (c == ST) ? ST : c + 2'd1;
    end else begin
      r = (c == SNT) ? SNT : c - 2'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bht_port_scheduler_if.sv
// Bundles the fetch lookup, execute update and BHT storage ports of the scheduler.
interface bht_port_scheduler_if #(
  parameter int IDX_W = 5
);
  logic             lookup_req;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_gnt;
  logic             lookup_valid;
  logic             lookup_pred;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             tbl_en;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata;
  logic             busy_init;

  modport slave (
    input  lookup_req, lookup_idx, upd_valid, upd_idx, upd_taken, tbl_rdata,
    output lookup_gnt, lookup_valid, lookup_pred, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, busy_init
  );

  modport master (
    output lookup_req, lookup_idx, upd_valid, upd_idx, upd_taken, tbl_rdata,
    input  lookup_gnt, lookup_valid, lookup_pred, upd_ready,
           tbl_en, tbl_we, tbl_addr, tbl_wdata, busy_init
  );

endinterface

// File: rtl/bht_update_fifo.sv
// Small FIFO holding resolved branch updates ({idx, taken}) until they commit.
module bht_update_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign head_data = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      wr_d = wr_q + AW'(1);
    end
    if (pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= push_data;
    end
  end

endmodule

// File: rtl/bht_port_scheduler.sv
// Arbitrates the single BHT port between fetch lookups and queued
// read-modify-write updates from execute; clears the table after reset.
module bht_port_scheduler
  import bht_sched_pkg::*;
#(
  parameter int         IDX_W      = 5,
  parameter int         QDEPTH     = 4,
  parameter int         STARVE_MAX = 3,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic                 clk,
  input logic                 arst_n,
  bht_port_scheduler_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  sched_state_e        state_q, state_d;
  logic [IDX_W-1:0]    sweep_q, sweep_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                lk_valid_q;
  logic                pred_q;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [IDX_W:0]   head_data;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;

  logic             en_c, we_c, gnt_c, force_c;
  logic [IDX_W-1:0] addr_c;
  logic [1:0]       wdata_c;

  assign head_idx   = head_data[IDX_W:1];
  assign head_taken = head_data[0];

  assign bus.upd_ready = (state_q != INIT) && !fifo_full;
  assign fifo_push     = bus.upd_valid && bus.upd_ready;

  bht_update_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (fifo_push),
    .push_data ({bus.upd_idx, bus.upd_taken}),
    .pop       (fifo_pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    starve_d = starve_q;
    en_c     = 1'b0;
    we_c     = 1'b0;
    gnt_c    = 1'b0;
    fifo_pop = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    force_c  = !fifo_empty && (fifo_full || (starve_q == STARVE_W'(STARVE_MAX)));

    case (state_q)
      INIT: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = sweep_q;
        wdata_c = INIT_STATE;
        sweep_d = sweep_q + IDX_W'(1);
        if (&sweep_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (force_c || (!bus.lookup_req && !fifo_empty)) begin
          en_c    = 1'b1;
          addr_c  = head_idx;
          state_d = UPD_WR;
        end else if (bus.lookup_req) begin
          gnt_c    = 1'b1;
          en_c     = 1'b1;
          addr_c   = bus.lookup_idx;
          starve_d = fifo_empty ? '0 : starve_q + STARVE_W'(1);
        end
      end
      UPD_WR: begin
        // Head is still the entry read last cycle; a same-cycle push lands behind it.
        en_c     = 1'b1;
        we_c     = 1'b1;
        addr_c   = head_idx;
        wdata_c  = sat_update(bus.tbl_rdata, head_taken);
        fifo_pop = 1'b1;
        starve_d = '0;
        state_d  = RUN;
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= INIT;
      sweep_q    <= '0;
      starve_q   <= '0;
      lk_valid_q <= 1'b0;
      pred_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      starve_q   <= starve_d;
      lk_valid_q <= gnt_c;
      if (lk_valid_q) begin
        pred_q <= bus.tbl_rdata[1];
      end
    end
  end

  // The port must be idle while reset is held even though the reset state is INIT.
  assign bus.tbl_en       = en_c && arst_n;
  assign bus.tbl_we       = we_c && arst_n;
  assign bus.tbl_addr     = addr_c;
  assign bus.tbl_wdata    = wdata_c;
  assign bus.lookup_gnt   = gnt_c;
  assign bus.lookup_valid = lk_valid_q;
  assign bus.lookup_pred  = lk_valid_q ? bus.tbl_rdata[1] : pred_q;
  assign bus.busy_init    = (state_q == INIT);

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Randomised scoreboard bench for bht_port_scheduler with a behavioural BHT model.
module tb_bht_port_scheduler;

  localparam int IDX_W      = 5;
  localparam int N          = 32;
  localparam int QDEPTH     = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;

  bht_port_scheduler_if #(.IDX_W(IDX_W)) bus();

  bht_port_scheduler #(
    .IDX_W      (IDX_W),
    .QDEPTH     (QDEPTH),
    .STARVE_MAX (STARVE_MAX),
    .INIT_STATE (2'b01)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Table storage: one access per cycle, registered read.
  logic [1:0] mem [N];
  always @(posedge clk) begin
    if (bus.tbl_en) begin
      if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
      bus.tbl_rdata <= mem[bus.tbl_addr];
    end
  end

  typedef struct {
    int idx;
    int val;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_lk[$];
  int  wr_log[$];
  int  arr_model [N];
  int  committed [N];
  int  occ, cons, last_pred;
  bit  prev_upd_rd;
  bit  run_chk = 1'b0;
  int  checks = 0;
  int  errors = 0;

  function automatic int sat(int c, bit tk);
    if (tk) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected by the model", name);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      arr_model[i] = 1;
      committed[i] = 1;
    end
    exp_wr.delete();
    exp_lk.delete();
    occ = 0;
    cons = 0;
    last_pred = 0;
    prev_upd_rd = 1'b0;
  endtask

  // Scoreboard monitor: occupancy/starvation rules, lookup responses, committed writes.
  always @(negedge clk) begin
    wr_t e;
    int  pe;
    int  ui;
    bit  forced;
    if (run_chk) begin
      forced = (occ > 0) && (occ == QDEPTH || cons == STARVE_MAX);
      chk("upd_ready", int'(bus.upd_ready), int'(occ < QDEPTH));
      if (prev_upd_rd) begin
        chk("upd_wr_follows_rd", int'(bus.tbl_we), 1);
        chk("no_gnt_in_upd_wr", int'(bus.lookup_gnt), 0);
      end else if (forced) begin
        chk("forced_no_gnt", int'(bus.lookup_gnt), 0);
      end else if (bus.lookup_req) begin
        chk("lookup_granted", int'(bus.lookup_gnt), 1);
      end else if (occ == 0) begin
        chk("idle_no_access", int'(bus.tbl_en), 0);
      end else begin
        chk("update_started", int'(bus.tbl_en && !bus.tbl_we), 1);
      end

      if (bus.lookup_valid) begin
        if (exp_lk.size() == 0) begin
          fail_now("lookup_valid_unexpected");
        end else begin
          pe = exp_lk.pop_front();
          chk("lookup_pred", int'(bus.lookup_pred), pe);
          last_pred = pe;
        end
      end else begin
        chk("lookup_valid_latency", exp_lk.size(), 0);
        chk("lookup_pred_hold", int'(bus.lookup_pred), last_pred);
      end

      if (bus.lookup_gnt) begin
        chk("gnt_access", int'(bus.tbl_en && !bus.tbl_we), 1);
        chk("gnt_addr", int'(bus.tbl_addr), int'(bus.lookup_idx));
        pe = committed[bus.lookup_idx] / 2;
        exp_lk.push_back(pe);
        cons = (occ > 0) ? cons + 1 : 0;
        $display("lookup idx=%0d expect_pred=%0d", bus.lookup_idx, pe);
      end else if (bus.tbl_en && !bus.tbl_we) begin
        if (exp_wr.size() == 0) fail_now("update_read_unexpected");
        else chk("upd_rd_addr", int'(bus.tbl_addr), exp_wr[0].idx);
      end

      if (bus.tbl_en && bus.tbl_we) begin
        if (exp_wr.size() == 0) begin
          fail_now("table_write_unexpected");
        end else begin
          e = exp_wr.pop_front();
          chk("upd_wr_addr", int'(bus.tbl_addr), e.idx);
          chk("upd_wr_data", int'(bus.tbl_wdata), e.val);
          committed[e.idx] = e.val;
          wr_log.push_back(int'(bus.tbl_wdata));
          occ--;
          cons = 0;
          $display("update idx=%0d wdata=%0d expect=%0d", bus.tbl_addr, bus.tbl_wdata, e.val);
        end
      end
      prev_upd_rd = bus.tbl_en && !bus.tbl_we && !bus.lookup_gnt;

      if (bus.upd_valid && bus.upd_ready) begin
        ui = int'(bus.upd_idx);
        arr_model[ui] = sat(arr_model[ui], bus.upd_taken);
        exp_wr.push_back('{idx: ui, val: arr_model[ui]});
        occ++;
      end
    end
  end

  task automatic reset_check();
    chk("rst_busy_init", int'(bus.busy_init), 1);
    chk("rst_lookup_gnt", int'(bus.lookup_gnt), 0);
    chk("rst_lookup_valid", int'(bus.lookup_valid), 0);
    chk("rst_lookup_pred", int'(bus.lookup_pred), 0);
    chk("rst_upd_ready", int'(bus.upd_ready), 0);
    chk("rst_tbl_en", int'(bus.tbl_en), 0);
    chk("rst_tbl_we", int'(bus.tbl_we), 0);
  endtask

  // Expects the cycle after reset release to be the first sweep write.
  task automatic sweep_check();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("sweep_en", int'(bus.tbl_en), 1);
      chk("sweep_we", int'(bus.tbl_we), 1);
      chk("sweep_addr", int'(bus.tbl_addr), k);
      chk("sweep_wdata", int'(bus.tbl_wdata), 1);
      chk("sweep_busy", int'(bus.busy_init), 1);
      chk("sweep_no_gnt", int'(bus.lookup_gnt), 0);
      chk("sweep_no_ready", int'(bus.upd_ready), 0);
    end
    bus.lookup_req = 1'b0;
    @(negedge clk);
    chk("busy_init_fall", int'(bus.busy_init), 0);
    @(posedge clk);
    #1;
    run_chk = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    bus.lookup_req = 1'b0;
    bus.upd_valid = 1'b0;
    for (int i = 0; i < 60 && (exp_wr.size() != 0 || exp_lk.size() != 0); i++) @(negedge clk);
    chk("drain_done", exp_wr.size() + exp_lk.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_lookup(int idx, int exp_pred);
    @(posedge clk);
    #1;
    bus.lookup_req = 1'b1;
    bus.lookup_idx = IDX_W'(idx);
    @(negedge clk);
    chk("dir_gnt_same_cycle", int'(bus.lookup_gnt), 1);
    @(posedge clk);
    #1;
    bus.lookup_req = 1'b0;
    @(negedge clk);
    chk("dir_lookup_valid", int'(bus.lookup_valid), 1);
    chk("dir_lookup_pred", int'(bus.lookup_pred), exp_pred);
  endtask

  task automatic push_upd(int idx, bit tk);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b1;
    bus.upd_idx = IDX_W'(idx);
    bus.upd_taken = tk;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.upd_ready) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) fail_now("push_timeout");
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
  endtask

  task automatic random_phase(int cycles, int lk_pct, int up_pct);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      bus.lookup_req = ($urandom_range(0, 99) < lk_pct);
      bus.lookup_idx = IDX_W'($urandom_range(0, 7));
      bus.upd_valid  = ($urandom_range(0, 99) < up_pct);
      bus.upd_idx    = IDX_W'($urandom_range(0, 7));
      bus.upd_taken  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int sat_up [4];
    int sat_dn [4];
    logic [5:0] gv6, wv6;
    logic [6:0] rv7, gv7;
    bit found;
    sat_up = '{2, 3, 3, 3};
    sat_dn = '{2, 1, 0, 0};

    bus.lookup_req = 1'b1;
    bus.lookup_idx = '0;
    bus.upd_valid = 1'b0;
    bus.upd_idx = '0;
    bus.upd_taken = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_check();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    sweep_check();

    do_lookup(7, 0);

    wr_log.delete();
    for (int i = 0; i < 4; i++) push_upd(3, 1'b1);
    drain();
    chk("sat_up_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("sat_up_value", wr_log[i], sat_up[i]);
    do_lookup(3, 1);
    wr_log.delete();
    for (int i = 0; i < 4; i++) push_upd(3, 1'b0);
    drain();
    chk("sat_dn_count", wr_log.size(), 4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) chk("sat_dn_value", wr_log[i], sat_dn[i]);
    do_lookup(3, 0);

    // Starvation: grants, grants, grants, update read, update write, grant.
    @(posedge clk);
    #1;
    bus.lookup_req = 1'b1;
    bus.lookup_idx = IDX_W'(1);
    bus.upd_valid = 1'b1;
    bus.upd_idx = IDX_W'(9);
    bus.upd_taken = 1'b1;
    @(negedge clk);
    chk("starve_push_ready", int'(bus.upd_ready), 1);
    chk("starve_push_gnt", int'(bus.lookup_gnt), 1);
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    gv6 = '0;
    wv6 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gv6 = {gv6[4:0], bus.lookup_gnt};
      wv6 = {wv6[4:0], bus.tbl_we};
    end
    chk("starve_gnt_pattern", int'(gv6), int'(6'b111001));
    chk("starve_we_pattern", int'(wv6), int'(6'b000010));
    drain();

    // Full queue under continuous lookups.
    @(posedge clk);
    #1;
    bus.lookup_req = 1'b1;
    bus.lookup_idx = IDX_W'(2);
    rv7 = '0;
    gv7 = '0;
    for (int i = 0; i < 7; i++) begin
      bus.upd_valid = (i < 4);
      bus.upd_idx = IDX_W'($urandom_range(0, 7));
      bus.upd_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      rv7 = {rv7[5:0], bus.upd_ready};
      gv7 = {gv7[5:0], bus.lookup_gnt};
      @(posedge clk);
      #1;
    end
    chk("full_ready_pattern", int'(rv7), int'(7'b1111001));
    chk("full_gnt_pattern", int'(gv7), int'(7'b1111001));
    drain();

    random_phase(800, 65, 45);
    drain();
    random_phase(600, 95, 70);
    drain();

    // Reset while an update write is in flight with two entries queued.
    @(posedge clk);
    #1;
    run_chk = 1'b0;
    bus.lookup_req = 1'b1;
    bus.lookup_idx = '0;
    bus.upd_valid = 1'b1;
    bus.upd_idx = IDX_W'(12);
    bus.upd_taken = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    bus.lookup_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.tbl_en && bus.tbl_we) found = 1'b1;
    end
    chk("midrst_upd_wr_reached", int'(found), 1);
    arst_n = 1'b0;
    #1;
    reset_check();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_check();
    bus.lookup_req = 1'b1;
    arst_n = 1'b1;
    sweep_check();
    repeat (20) @(negedge clk);
    do_lookup(12, 0);
    repeat (5) @(negedge clk);
    chk("midrst_no_pending", exp_wr.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
